// File: rtl/riscv_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter_pkg
// Shared definitions for the D/I cache-line memory arbiter:
//   arb_state_t : arbiter FSM states (idle, serving D side, serving I side)
//   arb_gnt_t   : grant encoding used for the round-robin last-grant record
//   pickGrant   : chooses the winning side for a set of pending requests
// ---------------------------------------------------------------------------
package riscv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_BUSY = 2'd1,
        ST_I_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_D = 1'b0,
        GNT_I = 1'b1
    } arb_gnt_t;

    // On a tie the side that was not served last wins, so neither cache
    // can starve the other while both keep requesting.
    function automatic arb_gnt_t pickGrant(input logic dReq,
                                           input logic iReq,
                                           input arb_gnt_t lastGnt);
        arb_gnt_t gnt;
        if (dReq && iReq) begin
            gnt = (lastGnt == GNT_I) ? GNT_D : GNT_I;
        end else if (dReq) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_I;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one DRAM line port between the D-cache and I-cache refill FSMs.
// Round-robin arbitration, one transaction at a time, with a sticky timeout
// flag if the DRAM takes TIMEOUT cycles or more to answer.
//
// Parameters:
//   DATA_WIDTH : cache line width in bits
//   S_ADDR     : line-address width
//   TIMEOUT    : wait cycles without mem_ready before the error flag sets
//
// Ports:
//   i_riscv_arb_clk / i_riscv_arb_rst_n : clock, synchronous active-low reset
//   i_riscv_arb_d_wren/_d_rden/_d_addr/_d_wdata : D-side line request
//   o_riscv_arb_d_ready/_d_rdata                : D-side completion and data
//   i_riscv_arb_i_rden/_i_addr                  : I-side line read request
//   o_riscv_arb_i_ready/_i_rdata                : I-side completion and data
//   o_riscv_arb_mem_wren/_rden/_addr/_wdata     : registered DRAM command
//   i_riscv_arb_mem_rdata/_mem_ready            : DRAM response
//   o_riscv_arb_timeout                         : sticky DRAM timeout flag
// ---------------------------------------------------------------------------
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_riscv_arb_clk,
    input  logic                  i_riscv_arb_rst_n,
    input  logic                  i_riscv_arb_d_wren,
    input  logic                  i_riscv_arb_d_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_d_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_d_wdata,
    output logic                  o_riscv_arb_d_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_d_rdata,
    input  logic                  i_riscv_arb_i_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_i_addr,
    output logic                  o_riscv_arb_i_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_i_rdata,
    output logic                  o_riscv_arb_mem_wren,
    output logic                  o_riscv_arb_mem_rden,
    output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata,
    input  logic                  i_riscv_arb_mem_ready,
    output logic                  o_riscv_arb_timeout
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t            r_state;
    arb_gnt_t              r_lastGnt;
    logic                  r_memWren;
    logic                  r_memRden;
    logic [S_ADDR-1:0]     r_memAddr;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic [CNT_W-1:0]      r_waitCnt;
    logic                  r_timeout;

    logic                  w_dReq;
    logic                  w_iReq;
    logic                  w_anyReq;
    arb_gnt_t              w_gnt;

    assign w_dReq   = i_riscv_arb_d_wren | i_riscv_arb_d_rden;
    assign w_iReq   = i_riscv_arb_i_rden;
    assign w_anyReq = w_dReq | w_iReq;
    assign w_gnt    = pickGrant(w_dReq, w_iReq, r_lastGnt);

    // Main FSM. The DRAM command is captured once at the grant edge and then
    // held from these registers, so requesters may change or drop their
    // inputs mid-transaction without disturbing the DRAM. Returning to IDLE
    // clears the strobes, which guarantees at least one low cycle between
    // transactions. The last-grant record only moves when a transaction
    // finishes; reset leaves it at I so D wins the first tie.
    always_ff @(posedge i_riscv_arb_clk) begin
        if (!i_riscv_arb_rst_n) begin
            r_state    <= ST_IDLE;
            r_lastGnt  <= GNT_I;
            r_memWren  <= 1'b0;
            r_memRden  <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        if (w_gnt == GNT_D) begin
                            r_state    <= ST_D_BUSY;
                            r_memWren  <= i_riscv_arb_d_wren;
                            r_memRden  <= ~i_riscv_arb_d_wren;
                            r_memAddr  <= i_riscv_arb_d_addr;
                            r_memWdata <= i_riscv_arb_d_wdata;
                        end else begin
                            r_state   <= ST_I_BUSY;
                            r_memWren <= 1'b0;
                            r_memRden <= 1'b1;
                            r_memAddr <= i_riscv_arb_i_addr;
                        end
                    end
                end
                ST_D_BUSY: begin
                    if (i_riscv_arb_mem_ready) begin
                        r_state   <= ST_IDLE;
                        r_memWren <= 1'b0;
                        r_memRden <= 1'b0;
                        r_lastGnt <= GNT_D;
                    end
                end
                ST_I_BUSY: begin
                    if (i_riscv_arb_mem_ready) begin
                        r_state   <= ST_IDLE;
                        r_memWren <= 1'b0;
                        r_memRden <= 1'b0;
                        r_lastGnt <= GNT_I;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_memWren <= 1'b0;
                    r_memRden <= 1'b0;
                end
            endcase
        end
    end

    // DRAM wait watchdog. The counter restarts on every grant and counts
    // busy cycles without mem_ready, saturating at TIMEOUT. The flag rises on
    // the same edge the count reaches TIMEOUT and is only cleared by reset;
    // the FSM itself keeps waiting for the DRAM.
    always_ff @(posedge i_riscv_arb_clk) begin
        if (!i_riscv_arb_rst_n) begin
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_anyReq) begin
                r_waitCnt <= '0;
            end
        end else if (!i_riscv_arb_mem_ready && (r_waitCnt != CNT_MAX)) begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
            if (r_waitCnt == (CNT_MAX - CNT_W'(1))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Completion is routed combinationally to the side being served only,
    // so a stray mem_ready while idle never reaches either cache.
    assign o_riscv_arb_d_ready   = (r_state == ST_D_BUSY) & i_riscv_arb_mem_ready;
    assign o_riscv_arb_i_ready   = (r_state == ST_I_BUSY) & i_riscv_arb_mem_ready;
    assign o_riscv_arb_d_rdata   = i_riscv_arb_mem_rdata;
    assign o_riscv_arb_i_rdata   = i_riscv_arb_mem_rdata;

    assign o_riscv_arb_mem_wren  = r_memWren;
    assign o_riscv_arb_mem_rden  = r_memRden;
    assign o_riscv_arb_mem_addr  = r_memAddr;
    assign o_riscv_arb_mem_wdata = r_memWdata;
    assign o_riscv_arb_timeout   = r_timeout;

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- DATA_WIDTH, 128, cache line width in bits.
- S_ADDR, 10, line-address width (ADDR - BYTE_OFF).
- TIMEOUT, 1024, maximum cycles to wait for mem_ready before flagging an error.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- i_riscv_arb_clk, in, 1, the single clock.
- i_riscv_arb_rst_n, in, 1, reset; synchronous, active-low.
- i_riscv_arb_d_wren, in, 1, D-cache FSM line write request.
- i_riscv_arb_d_rden, in, 1, D-cache FSM line read request.
- i_riscv_arb_d_addr, in, S_ADDR, D-cache line address.
- i_riscv_arb_d_wdata, in, DATA_WIDTH, D-cache write line.
- o_riscv_arb_d_ready, out, 1, D-side completion pulse.
- o_riscv_arb_d_rdata, out, DATA_WIDTH, D-side read line.
- i_riscv_arb_i_rden, in, 1, I-cache FSM line read request.
- i_riscv_arb_i_addr, in, S_ADDR, I-cache line address.
- o_riscv_arb_i_ready, out, 1, I-side completion pulse.
- o_riscv_arb_i_rdata, out, DATA_WIDTH, I-side read line.
- o_riscv_arb_mem_wren, out, 1, shared DRAM write strobe.
- o_riscv_arb_mem_rden, out, 1, shared DRAM read strobe.
- o_riscv_arb_mem_addr, out, S_ADDR, shared DRAM line address.
- o_riscv_arb_mem_wdata, out, DATA_WIDTH, shared DRAM write data.
- i_riscv_arb_mem_rdata, in, DATA_WIDTH, shared DRAM read data.
- i_riscv_arb_mem_ready, in, 1, shared DRAM completion.
- o_riscv_arb_timeout, out, 1, sticky error flag.

Function
REQ-003 The block SHALL use an FSM with states IDLE, D_BUSY and I_BUSY.
REQ-004 In IDLE, a request SHALL be any of d_wren, d_rden or i_rden being high.
- If one side requests, that side SHALL be granted at the next edge.
- If both sides request, the side not granted last SHALL win (round-robin).
REQ-005 At the grant edge, the block SHALL register the granted side's addr, wdata and op into the mem outputs.
- The I side SHALL use wren=0 and rden=1.
- If d_wren and d_rden are both high, the op SHALL be a write (wren=1, rden=0).
REQ-006 In D_BUSY and I_BUSY, the mem strobes, addr and wdata SHALL be held stable from the latched values, regardless of changes on the requester inputs.
REQ-007 In a BUSY state, the ready outputs SHALL be routed combinationally:
- o_*_ready SHALL equal i_riscv_arb_mem_ready for the granted side only.
- The non-granted side's ready SHALL be 0.
REQ-008 Both rdata outputs SHALL be combinational pass-throughs of i_riscv_arb_mem_rdata, valid only when the matching ready is high.
REQ-009 When mem_ready is sampled high in a BUSY state, the next edge SHALL:
- move the FSM to IDLE,
- clear mem_wren and mem_rden,
- update the last-grant register to the side just served.
REQ-010 When the FSM is in IDLE, the mem strobes SHALL be 0, so the DRAM always sees at least one low cycle between transactions. Back-to-back grant latency SHALL be exactly 2 cycles from the ready cycle.
REQ-011 Request-to-strobe latency SHALL be 1 cycle: a request sampled in IDLE at edge t SHALL give a strobe high after edge t.
REQ-012 Requesters SHALL hold requests until ready. If a request drops while BUSY, the transaction SHALL still complete and ready SHALL still pulse to that side.
REQ-013 A mem_ready that arrives in IDLE SHALL be ignored, and both ready outputs SHALL be 0 in IDLE.
REQ-014 A wait counter SHALL:
- clear on every grant,
- increment each BUSY cycle without mem_ready,
- saturate at TIMEOUT.
On reaching TIMEOUT, o_riscv_arb_timeout SHALL set and stay set until reset. The FSM SHALL keep waiting.

Reset
REQ-015 While i_riscv_arb_rst_n is low at an edge, the block SHALL set the following, including mid-transaction:
- state = IDLE,
- mem_wren = mem_rden = 0,
- mem_addr = 0 and mem_wdata = 0,
- wait counter = 0 and timeout = 0,
- last-grant = I, so that D wins the first tie.
REQ-016 Reset SHALL have no asynchronous path.

Structure
REQ-017 The FSM state enum and the grant encoding (GNT_D, GNT_I) SHALL reside in the shared riscv package.
REQ-018 The block SHALL be a single module with no sub-modules. It SHALL be instantiated between riscv_core's D/I memory ports and a single DRAM model.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Lone D read of addr 0x12A, DRAM latency 5: mem_rden high 1 cycle after the request, addr 0x12A held 5 cycles, d_ready pulses once, i_ready stays 0, then one IDLE cycle with strobes low.
- Simultaneous d_rden (addr 0x010) and i_rden (addr 0x020) after reset: D is served first, then I, and mem_addr sequence is 0x010 then 0x020.
- Both sides requesting continuously for 6 transactions: grants alternate D, I, D, I, D, I with no starvation.
- d_wren and d_rden both high, wdata 0xA5A5...: mem_wren=1, mem_rden=0, mem_wdata=0xA5A5... stable until ready.
- Reset low mid-I transaction: strobes 0 on the next edge, no ready pulse, and the first tie after reset goes to D.
- TIMEOUT=8 with mem_ready held low: timeout sets after 8 BUSY cycles and remains set after a later ready.
